// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: A - B computed one bit per clock, LSB first.
// A start in IDLE captures the operands, WIDTH SHIFT cycles run a single
// full-subtractor cell, and a one-cycle DONE state publishes Diff/Bout.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    // Partial result holds only WIDTH-1 bits: the last difference bit goes
    // straight into Diff on the final SHIFT edge, so it never needs storing.
    logic [WIDTH-2:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;

    logic             bit_d;
    logic             br_next;
    logic [WIDTH-1:0] res_shift;

    // One full-subtractor cell on the current operand LSBs, and the result
    // register with the new bit shifted in from the MSB side.
    always_comb begin
        bit_d     = a_q[0] ^ b_q[0] ^ br_q;
        br_next   = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
        res_shift = {bit_d, res_q};
    end

    // Next-state logic: capture in IDLE, shift in SHIFT, publish on entry to DONE.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        bout_d  = bout_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    a_d     = A;
                    b_d     = B;
                    res_d   = '0;
                    cnt_d   = '0;
                    br_d    = 1'b0;
                end
            end
            SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = res_shift[WIDTH-1:1];
                br_d  = br_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d = DONE;
                    diff_d  = res_shift;
                    bout_d  = br_next;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
        end
    end

    assign Diff = diff_q;
    assign Bout = bout_q;
    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=4: directed table,
// start re-pulse and mid-operation reset sequences, exhaustive sweep with
// start held high, and randomized operations against an arithmetic model.
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W-1:0] Diff;
    logic         Bout;
    logic         busy;
    logic         done;

    int total = 0;
    int bad   = 0;

    // Values Diff/Bout must be holding between operations.
    int prev_d  = 0;
    int prev_bo = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] d;
        logic         bo;
    } vec_t;

    vec_t tbl[6];

    serial_subtractor #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .A    (A),
        .B    (B),
        .Diff (Diff),
        .Bout (Bout),
        .busy (busy),
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endfunction

    // Reference: plain modular arithmetic on integers.
    function automatic int model_diff(input int a, input int b);
        return (a - b + (1 << W)) % (1 << W);
    endfunction

    function automatic int model_bout(input int a, input int b);
        return (a < b) ? 1 : 0;
    endfunction

    // Run one operation from IDLE and check busy length, single done pulse,
    // latency, result, and that outputs hold their old values until DONE.
    // Operand inputs are scrambled during SHIFT; repulse also re-asserts start
    // with A=B=1 mid-operation.
    task automatic do_op(input int a, input int b, input int exp_d, input int exp_bo,
                         input bit repulse, input string nm);
        int busy_n, done_n, lat, dv, bv;
        busy_n = 0; done_n = 0; lat = -1; dv = -1; bv = -1;
        @(negedge clk);
        A = W'(a); B = W'(b); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (busy) busy_n++;
            if (done) begin
                if (done_n == 0) begin
                    lat = c; dv = int'(Diff); bv = int'(Bout);
                end
                done_n++;
            end else if (c < 4) begin
                chk({nm, " hold_diff"}, int'(Diff), prev_d);
                chk({nm, " hold_bout"}, int'(Bout), prev_bo);
            end
            if (repulse && c == 1) begin
                start = 1'b1; A = 4'd1; B = 4'd1;
            end else begin
                start = 1'b0; A = W'($urandom); B = W'($urandom);
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk({nm, " busy_cycles"}, busy_n, W);
        chk({nm, " done_pulses"}, done_n, 1);
        chk({nm, " latency"}, lat, W);
        chk({nm, " diff"}, dv, exp_d);
        chk({nm, " bout"}, bv, exp_bo);
        prev_d  = exp_d;
        prev_bo = exp_bo;
    endtask

    initial begin
        int dn, cyc, last_done, sweep_dones;
        int qa[$];
        int qb[$];
        int ea, eb;

        tbl[0] = '{a: 4'd9,  b: 4'd3,  d: 4'd6,  bo: 1'b0};
        tbl[1] = '{a: 4'd3,  b: 4'd9,  d: 4'hA,  bo: 1'b1};
        tbl[2] = '{a: 4'd0,  b: 4'd1,  d: 4'd15, bo: 1'b1};
        tbl[3] = '{a: 4'd15, b: 4'd15, d: 4'd0,  bo: 1'b0};
        tbl[4] = '{a: 4'd0,  b: 4'd0,  d: 4'd0,  bo: 1'b0};
        tbl[5] = '{a: 4'd12, b: 4'd5,  d: 4'd7,  bo: 1'b0};

        // Reset state
        rst = 1'b1; start = 1'b0; A = '0; B = '0;
        repeat (3) @(negedge clk);
        chk("reset diff", int'(Diff), 0);
        chk("reset bout", int'(Bout), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 6; i++)
            do_op(tbl[i].a, tbl[i].b, tbl[i].d, tbl[i].bo, 1'b0, $sformatf("tbl%0d", i));

        // start re-pulsed during SHIFT of 9-3 must be ignored
        do_op(9, 3, 6, 0, 1'b1, "repulse");

        // Reset two SHIFT cycles into 12-5
        @(negedge clk);
        A = 4'd12; B = 4'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst diff", int'(Diff), 0);
        chk("midrst bout", int'(Bout), 0);
        chk("midrst busy", int'(busy), 0);
        chk("midrst done", int'(done), 0);
        dn = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) dn++;
        end
        rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("midrst no_done", dn, 0);
        prev_d = 0; prev_bo = 0;
        do_op(12, 5, 7, 0, 1'b0, "after_rst");

        // Exhaustive sweep, start held high: one accept every W+2 cycles
        @(negedge clk);
        cyc = 0; last_done = -1; sweep_dones = 0;
        for (int i = 0; i < 256; i++) begin
            A = W'(i / 16); B = W'(i % 16); start = 1'b1;
            qa.push_back(i / 16);
            qb.push_back(i % 16);
            for (int c = 0; c < W + 2; c++) begin
                @(negedge clk);
                cyc++;
                if (done) begin
                    sweep_dones++;
                    if (qa.size() > 0) begin
                        ea = qa.pop_front();
                        eb = qb.pop_front();
                        chk($sformatf("sweep %0d-%0d diff", ea, eb), int'(Diff), model_diff(ea, eb));
                        chk($sformatf("sweep %0d-%0d bout", ea, eb), int'(Bout), model_bout(ea, eb));
                    end
                    if (last_done >= 0)
                        chk("sweep spacing", cyc - last_done, W + 2);
                    last_done = cyc;
                end
            end
        end
        start = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done) sweep_dones++;
        end
        chk("sweep done_count", sweep_dones, 256);
        prev_d  = model_diff(15, 15);
        prev_bo = model_bout(15, 15);

        // Randomized operations against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            int ra, rb;
            ra = int'($urandom_range(15, 0));
            rb = int'($urandom_range(15, 0));
            do_op(ra, rb, model_diff(ra, rb), model_bout(ra, rb), i[0],
                  $sformatf("rand%0d %0d-%0d", i, ra, rb));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
